// File: rtl/mips_alu_mdu.sv
// Registered MIPS execute unit: single-cycle ALU ops plus iterative multiply/divide into HI/LO.
// Define MIPS_MDU_SIGNED_EN for signed MULT/DIV; otherwise they execute as MULTU/DIVU.
module mips_alu_mdu #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [OPW-1:0]   opr_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             extbit_o,
  output logic             of_o,
  output logic             zf_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o
);

  // state | meaning
  // IDLE  | accepting issues; single-cycle ops complete here
  // RUN   | one multiply/divide bit per cycle, counter WIDTH-1..0
  // FIX   | sign correction, HI/LO write, done pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
  localparam logic [OPW-1:0] OP_AND   = OPW'(3);
  localparam logic [OPW-1:0] OP_OR    = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(5);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(6);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(7);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(8);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(11);
  localparam logic [OPW-1:0] OP_MFHI  = OPW'(12);
  localparam logic [OPW-1:0] OP_MFLO  = OPW'(13);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef MIPS_MDU_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ext_q, ext_d;
  logic             of_q, of_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Single-cycle ALU
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ext, alu_of;

  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    alu_res = '0;
    alu_ext = 1'b0;
    alu_of  = 1'b0;
    case (opr_i)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_ext = add_w[WIDTH];
        alu_of  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_ext = sub_w[WIDTH];
        alu_of  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Issue-time operand conditioning; odd mul/div opcodes are the signed variants
  logic             is_mdu_op, signed_op;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_mdu_op = (opr_i >= OP_MULTU) && (opr_i <= OP_DIV);
  assign signed_op = SIGNED_EN && opr_i[0];
  assign mag_a     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;

  // Iteration step: shift-add multiply, restoring divide
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opb_q};
  assign div_diff = div_sh[WIDTH-1:0] - opb_q;

  // Final sign correction
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_neg = -prod;
  assign quo_fix  = div_zero_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    res_d      = res_q;
    ext_d      = ext_q;
    of_d       = of_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dz_d       = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (is_mdu_op) begin
            state_d    = S_RUN;
            cnt_d      = CNTW'(WIDTH-1);
            acc_hi_d   = '0;
            acc_lo_d   = mag_a;
            opb_d      = mag_b;
            is_div_d   = opr_i[1];
            neg_res_d  = signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_rem_d  = signed_op && a_i[WIDTH-1];
            div_zero_d = opr_i[1] && (b_i == '0);
          end else begin
            res_d  = alu_res;
            ext_d  = alu_ext;
            of_d   = alu_of;
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
          dz_d = div_zero_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      res_q      <= '0;
      ext_q      <= 1'b0;
      of_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      res_q      <= res_d;
      ext_q      <= ext_d;
      of_q       <= of_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  assign res_o    = res_q;
  assign extbit_o = ext_q;
  assign of_o     = of_q;
  assign zf_o     = (res_q == '0);
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign dz_o     = dz_q;

endmodule

// File: tb/tb_mips_alu_mdu.sv
// Directed-vector bench for mips_alu_mdu at WIDTH=32; expectations follow MIPS_MDU_SIGNED_EN.
module tb_mips_alu_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   opr;
  logic [W-1:0] a, b;
  logic [W-1:0] res, hi, lo;
  logic         extbit, of, zf, busy, done, dz;

  int errors = 0;
  int checks = 0;

  mips_alu_mdu #(.WIDTH(W), .OPW(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .opr_i(opr), .a_i(a), .b_i(b),
    .res_o(res), .extbit_o(extbit), .of_o(of), .zf_o(zf), .hi_o(hi), .lo_o(lo),
    .busy_o(busy), .done_o(done), .dz_o(dz)
  );

  always #5 clk = ~clk;

  // Drives one issue edge; returns at posedge+1 with start released.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    start = 1'b1; opr = op; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycles from the issue edge until done is seen (1 = next cycle), capped at 200.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; opr = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({res, zf, extbit, of, hi, lo, busy, done, dz} !== {32'h0, 1'b1, 1'b0, 1'b0, 64'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset: res=%h zf=%b ext=%b of=%b hi=%h lo=%h busy=%b done=%b dz=%b",
               res, zf, extbit, of, hi, lo, busy, done, dz);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    issue(4'h1, 32'h7FFF_FFFF, 32'h0000_0001);
    checks++;
    if ({res, of, extbit, zf, done} !== {32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_ovf: res=%h of=%b ext=%b zf=%b done=%b want 80000000 1 0 0 1",
               res, of, extbit, zf, done);
    end
    @(posedge clk); #1;
    checks++;
    if ({res, done} !== {32'h8000_0000, 1'b0}) begin
      errors++;
      $display("FAIL add_hold: res=%h done=%b want 80000000 0", res, done);
    end
    issue(4'h1, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++;
    if ({res, of, extbit, zf} !== {32'h0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_carry: res=%h of=%b ext=%b zf=%b want 0 0 1 1", res, of, extbit, zf);
    end
  endtask

  task automatic test_sub;
    issue(4'h2, 32'd5, 32'd5);
    checks++;
    if ({res, zf, extbit, of} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_zero: res=%h zf=%b ext=%b of=%b want 0 1 0 0", res, zf, extbit, of);
    end
    issue(4'h2, 32'd0, 32'd1);
    checks++;
    if ({res, extbit, of} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow: res=%h ext=%b of=%b want FFFFFFFF 1 0", res, extbit, of);
    end
    issue(4'h2, 32'h8000_0000, 32'd1);
    checks++;
    if ({res, extbit, of} !== {32'h7FFF_FFFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf: res=%h ext=%b of=%b want 7FFFFFFF 0 1", res, extbit, of);
    end
  endtask

  task automatic test_logic;
    logic [3:0]   ops [8]  = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h7, 4'h0, 4'hF};
    logic [W-1:0] va  [8]  = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'h0000_0001, 32'h1234_5678, 32'h1234_5678};
    logic [W-1:0] vb  [8]  = '{32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0000_0001,
                               32'h0000_0001, 32'hFFFF_FFFF, 32'h1, 32'h1};
    logic [W-1:0] exp [8]  = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'h1,
                               32'h0, 32'h1, 32'h0, 32'h0};
    // Preload flags so the zero-flag ops below must clear them.
    issue(4'h1, 32'h7FFF_FFFF, 32'h1);
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], va[i], vb[i]);
      checks++;
      if ({res, extbit, of, done} !== {exp[i], 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL logic_op%0h: res=%h ext=%b of=%b done=%b want %h 0 0 1",
                 ops[i], res, extbit, of, done, exp[i]);
      end
    end
  endtask

  task automatic test_multu;
    int n;
    logic [W-1:0] res_before;
    issue(4'h1, 32'h0000_0010, 32'h0000_0002);
    res_before = res;
    issue(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL multu_busy: busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(n);
    checks++;
    if (n !== W + 2) begin
      errors++;
      $display("FAIL multu_latency: cycles=%0d want %0d", n, W + 2);
    end
    checks++;
    if ({hi, lo, busy, res, extbit, of} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0, res_before, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL multu_result: hi=%h lo=%h busy=%b res=%h ext=%b of=%b want FFFFFFFE 00000001 0 %h 0 0",
               hi, lo, busy, res, extbit, of, res_before);
    end
    @(posedge clk); #1;
    issue(4'hC, 32'h0, 32'h0);
    checks++;
    if ({res, done} !== {32'hFFFF_FFFE, 1'b1}) begin
      errors++;
      $display("FAIL mfhi: res=%h done=%b want FFFFFFFE 1", res, done);
    end
    issue(4'hD, 32'h0, 32'h0);
    checks++;
    if (res !== 32'h0000_0001) begin
      errors++;
      $display("FAIL mflo: res=%h want 00000001", res);
    end
  endtask

  task automatic test_signed;
    int n;
    logic [W-1:0] exp_hi, exp_lo;
    issue(4'h9, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(n);
`ifdef MIPS_MDU_SIGNED_EN
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA;
`else
    exp_hi = 32'h0000_0002; exp_lo = 32'hFFFF_FFFA;
`endif
    checks++;
    if ({n, hi, lo} !== {W + 2, exp_hi, exp_lo}) begin
      errors++;
      $display("FAIL mult: cycles=%0d hi=%h lo=%h want %0d %h %h", n, hi, lo, W + 2, exp_hi, exp_lo);
    end
    issue(4'hB, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(n);
`ifdef MIPS_MDU_SIGNED_EN
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
`else
    exp_hi = 32'h0000_0001; exp_lo = 32'h7FFF_FFFC;
`endif
    checks++;
    if ({n, hi, lo, dz} !== {W + 2, exp_hi, exp_lo, 1'b0}) begin
      errors++;
      $display("FAIL div_neg: cycles=%0d hi=%h lo=%h dz=%b want %0d %h %h 0", n, hi, lo, dz, W + 2, exp_hi, exp_lo);
    end
    issue(4'hB, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
`ifdef MIPS_MDU_SIGNED_EN
    exp_hi = 32'h0000_0000; exp_lo = 32'h8000_0000;
`else
    exp_hi = 32'h8000_0000; exp_lo = 32'h0000_0000;
`endif
    checks++;
    if ({hi, lo, dz} !== {exp_hi, exp_lo, 1'b0}) begin
      errors++;
      $display("FAIL div_min: hi=%h lo=%h dz=%b want %h %h 0", hi, lo, dz, exp_hi, exp_lo);
    end
  endtask

  task automatic test_divzero;
    int n;
    logic [W-1:0] res_before;
    logic         ext_before;
    res_before = res;
    ext_before = extbit;
    issue(4'hA, 32'h0000_1234, 32'h0);
    issue(4'h1, 32'h0000_0001, 32'h0000_0001);
    wait_done(n);
    checks++;
    if ({n, lo, hi, dz} !== {W + 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1}) begin
      errors++;
      $display("FAIL divu_zero: cycles=%0d lo=%h hi=%h dz=%b want %0d FFFFFFFF 00001234 1",
               n, lo, hi, dz, W + 1);
    end
    checks++;
    if ({res, extbit} !== {res_before, ext_before}) begin
      errors++;
      $display("FAIL busy_ignore: res=%h ext=%b want %h %b", res, extbit, res_before, ext_before);
    end
    @(posedge clk); #1;
    issue(4'h1, 32'd2, 32'd3);
    checks++;
    if ({res, dz} !== {32'd5, 1'b1}) begin
      errors++;
      $display("FAIL dz_hold: res=%h dz=%b want 00000005 1", res, dz);
    end
    issue(4'hA, 32'd7, 32'd2);
    wait_done(n);
    checks++;
    if ({lo, hi, dz} !== {32'd3, 32'd1, 1'b0}) begin
      errors++;
      $display("FAIL dz_clear: lo=%h hi=%h dz=%b want 3 1 0", lo, hi, dz);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(4'h8, 32'd3, 32'd5);
    wait_done(n);
    checks++;
    if ({n, hi, lo, busy} !== {W + 2, 32'd0, 32'd15, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d hi=%h lo=%h busy=%b want %0d 0 f 0", n, hi, lo, busy, W + 2);
    end
    issue(4'hA, 32'd100, 32'd7);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(n);
    checks++;
    if ({n, lo, hi} !== {W + 2, 32'd14, 32'd2}) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d lo=%h hi=%h want %0d e 2", n, lo, hi, W + 2);
    end
  endtask

  task automatic test_reset_abort;
    int pulses;
    issue(4'h1, 32'd1, 32'd2);
    issue(4'h9, 32'h0001_0000, 32'h0001_0000);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, hi, lo, res, done} !== {1'b0, 64'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rst_abort: busy=%b hi=%h lo=%h res=%h done=%b want 0 0 0 0 0", busy, hi, lo, res, done);
    end
    pulses = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_no_done: done/busy cycles=%0d want 0", pulses);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_multu;
    test_signed;
    test_divzero;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
